// File: rtl/gray_bin_pkg.sv
// Shared widths, output levels and divider state encoding for the gray mean binarizer.
// AUTO_THRESH_EN selects the adaptive (frame-mean) threshold build.
package gray_bin_pkg;

    localparam int SUM_W  = 30;
    localparam int CNT_W  = 22;
    localparam int STEP_W = $clog2(SUM_W);

    localparam logic [7:0] BIN_HI = 8'hFF;
    localparam logic [7:0] BIN_LO = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // A valid mean never exceeds 255; the clamp only guards against misuse.
    function automatic logic [7:0] sat_u8(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:8]) ? BIN_HI : q[7:0];
    endfunction

endpackage

// File: rtl/gray_mean_divider.sv
// Sequential restoring divider: SUM_W-bit sum by CNT_W-bit count, one quotient bit per
// cycle, 8-bit saturated result. Only built into the top when AUTO_THRESH_EN is defined.
module gray_mean_divider
    import gray_bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [7:0]       quotient,
    output div_state_t       state
);

    logic [SUM_W-1:0]  quo;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  dsr;
    logic [STEP_W-1:0] step;

    logic [CNT_W:0]    rem_shift;
    logic              q_bit;
    logic [CNT_W-1:0]  rem_next;

    // The remainder stays below the divisor, so CNT_W bits hold it between steps.
    always_comb begin
        rem_shift = {rem, quo[SUM_W-1]};
        q_bit     = (rem_shift >= {1'b0, dsr});
        rem_next  = q_bit ? CNT_W'(rem_shift - {1'b0, dsr}) : rem_shift[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            step     <= '0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        quo   <= dividend;
                        dsr   <= divisor;
                        rem   <= '0;
                        step  <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    rem  <= rem_next;
                    quo  <= {quo[SUM_W-2:0], q_bit};
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(SUM_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done     <= 1'b1;
                    quotient <= sat_u8(quo);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gray_mean_binarize.sv
// Binarizes the gray stream against the mean of the previous complete frame.
// AUTO_THRESH_EN builds the mean accumulator and divider; otherwise THRESH_INIT is fixed.
module gray_mean_binarize
    import gray_bin_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP   = 11'd640,
    parameter logic [10:0] IMG_VDISP   = 11'd480,
    parameter logic [7:0]  THRESH_INIT = 8'd128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic [7:0] per_img_Gray,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic [7:0] post_img_Bit,
    output logic [7:0] cur_thresh,
    output logic       mean_done
);

    // The pixel counter must hold a full frame without wrapping.
    if (int'(IMG_HDISP) * int'(IMG_VDISP) >= (1 << CNT_W)) begin : g_frame_too_big
        $error("gray_mean_binarize: frame size exceeds pixel counter width");
    end

    // One-cycle pixel path; post_frame_vsync doubles as the previous-vsync register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_Bit     <= BIN_LO;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_img_Bit     <= (per_frame_href && (per_img_Gray > cur_thresh)) ? BIN_HI : BIN_LO;
        end
    end

`ifdef AUTO_THRESH_EN

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       pend_thresh;
    logic             vs_rise;
    logic             vs_fall;
    logic             div_start;
    logic             div_done;
    logic [7:0]       div_quot;
    div_state_t       div_state;

    assign vs_rise = per_frame_vsync & ~post_frame_vsync;
    assign vs_fall = ~per_frame_vsync & post_frame_vsync;

    // An end of frame while a division is still running is dropped, not restarted.
    assign div_start = vs_fall && (cnt != '0) && (div_state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum         <= '0;
            cnt         <= '0;
            cur_thresh  <= THRESH_INIT;
            pend_thresh <= THRESH_INIT;
            mean_done   <= 1'b0;
        end else begin
            if (vs_rise) begin
                sum <= per_frame_href ? {{(SUM_W-8){1'b0}}, per_img_Gray} : '0;
                cnt <= per_frame_href ? CNT_W'(1) : '0;
            end else if (per_frame_vsync && per_frame_href) begin
                sum <= sum + {{(SUM_W-8){1'b0}}, per_img_Gray};
                cnt <= cnt + CNT_W'(1);
            end

            // Threshold only moves at frame start, so a frame is never split.
            if (vs_rise) begin
                cur_thresh <= pend_thresh;
            end

            mean_done <= div_done;
            if (div_done) begin
                pend_thresh <= div_quot;
            end
        end
    end

    gray_mean_divider u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum),
        .divisor  (cnt),
        .done     (div_done),
        .quotient (div_quot),
        .state    (div_state)
    );

`else

    assign cur_thresh = THRESH_INIT;
    assign mean_done  = 1'b0;

`endif

endmodule

// File: tb/tb_gray_mean_binarize.sv
// Randomized bench for gray_mean_binarize with a frame-level reference model.
// Honors AUTO_THRESH_EN the same way as the design.
module tb_gray_mean_binarize;

    localparam logic [7:0] THRESH_INIT = 8'd128;
`ifdef AUTO_THRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic [7:0] per_img_Gray = 8'd0;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic [7:0] post_img_Bit;
    logic [7:0] cur_thresh;
    logic       mean_done;

    gray_mean_binarize #(
        .IMG_HDISP   (11'd4),
        .IMG_VDISP   (11'd2),
        .THRESH_INIT (THRESH_INIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_img_Gray     (per_img_Gray),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_img_Bit     (post_img_Bit),
        .cur_thresh       (cur_thresh),
        .mean_done        (mean_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done  = 0;

    // reference model state
    logic [7:0] m_cur;
    logic [7:0] m_pend;
    longint     m_sum;
    int         m_cnt;
    bit         m_vs_prev;
    int         m_free_at;
    logic [7:0] exp_q[$];
    int         ready_q[$];
    logic [7:0] pix_q[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %02h expected %02h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cur     = THRESH_INIT;
        m_pend    = THRESH_INIT;
        m_sum     = 0;
        m_cnt     = 0;
        m_vs_prev = 1'b0;
        m_free_at = 0;
        exp_q.delete();
        ready_q.delete();
    endtask

    // drive one cycle, then compare every output against the model
    task automatic step(input logic v, input logic h, input logic [7:0] px);
        logic [7:0] e_vs, e_hr, e_bit, e_done;
        bit rise, fall;
        longint mean;
        per_frame_vsync = v;
        per_frame_href  = h;
        per_img_Gray    = px;
        @(posedge clk);
        cyc++;
        #1;
        e_done = 8'd0;
        if (!rst_n) begin
            model_reset();
            e_vs = 8'd0; e_hr = 8'd0; e_bit = 8'd0;
        end else begin
            e_vs  = {7'd0, v};
            e_hr  = {7'd0, h};
            e_bit = (h && px > m_cur) ? 8'hFF : 8'h00;
            rise  = v && !m_vs_prev;
            fall  = !v && m_vs_prev;
            if (AUTO) begin
                if (rise) begin
                    m_cur = m_pend;
                    m_sum = 0;
                    m_cnt = 0;
                end
                if (ready_q.size() > 0 && ready_q[0] == cyc) begin
                    m_pend = exp_q.pop_front();
                    void'(ready_q.pop_front());
                    e_done = 8'd1;
                end
                if (v && h) begin
                    m_sum += px;
                    m_cnt++;
                end
                if (fall && m_cnt != 0 && cyc >= m_free_at) begin
                    mean = m_sum / m_cnt;
                    exp_q.push_back((mean > 255) ? 8'hFF : 8'(mean));
                    ready_q.push_back(cyc + DIV_LAT);
                    m_free_at = cyc + DIV_LAT;
                end
            end
            m_vs_prev = v;
        end
        if (mean_done) n_done++;
        check("post_vsync", {7'd0, post_frame_vsync}, e_vs);
        check("post_href", {7'd0, post_frame_href}, e_hr);
        check("post_bit", post_img_Bit, e_bit);
        check("cur_thresh", cur_thresh, m_cur);
        check("mean_done", {7'd0, mean_done}, e_done);
    endtask

    task automatic do_reset(input int n, input bit vs_high);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(vs_high ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end
        rst_n = 1'b1;
    endtask

    // frame: 2 lead cycles, lines with 2-cycle gaps, then vertical blanking
    task automatic run_frame(input int lines, input int per_line, input int blank);
        logic [7:0] px;
        step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < per_line; p++) begin
                px = (pix_q.size() > 0) ? pix_q.pop_front() : 8'($urandom_range(0, 255));
                step(1'b1, 1'b1, px);
                if ($urandom_range(0, 7) == 0) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            end
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        end
        for (int b = 0; b < blank; b++) begin
            step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic fill(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) pix_q.push_back(val);
    endtask

    initial begin
        model_reset();
        do_reset(6, 1'b0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);

        // first frame after reset: default threshold boundary
        pix_q = '{8'd129, 8'd128, 8'd127, 8'd255, 8'd0, 8'd129, 8'd128, 8'd200};
        run_frame(2, 4, 50);

        // mean 40, then check 41/40 against it
        fill(8, 8'd40);
        run_frame(2, 4, 50);
        pix_q = '{8'd41, 8'd40, 8'd39, 8'd41, 8'd40, 8'd255, 8'd0, 8'd41};
        run_frame(2, 4, 50);

        // truncating mean: 1019 / 8 = 127
        pix_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd254};
        run_frame(2, 4, 50);
        pix_q = '{8'd128, 8'd127, 8'd126, 8'd200, 8'd128, 8'd127, 8'd0, 8'd255};
        run_frame(2, 4, 50);

        // short blanking after a mean-200 frame
        fill(8, 8'd200);
        run_frame(2, 4, 10);
        run_frame(2, 4, 50);
        pix_q = '{8'd201, 8'd200, 8'd199, 8'd255, 8'd201, 8'd200, 8'd10, 8'd250};
        run_frame(2, 4, 50);
        run_frame(2, 4, 50);

        // empty frame
        run_frame(0, 0, 40);
        run_frame(2, 4, 50);

        // reset 16 cycles into a division, released with vsync already high
        fill(8, 8'd40);
        run_frame(2, 4, 17);
        do_reset(3, 1'b1);
        pix_q = '{8'd129, 8'd128, 8'd40, 8'd41, 8'd129, 8'd128, 8'd0, 8'd255};
        run_frame(2, 4, 50);
        run_frame(2, 4, 50);

        // randomized frames: sizes, pixel spreads and blanking lengths
        for (int i = 0; i < 24; i++) begin
            int base;
            int lines;
            int per_line;
            base     = $urandom_range(0, 255);
            lines    = $urandom_range(0, 3);
            per_line = $urandom_range(1, 6);
            for (int p = 0; p < lines * per_line; p++) begin
                int v;
                v = base + $urandom_range(0, 40) - 20;
                pix_q.push_back((v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v));
            end
            run_frame(lines, per_line, $urandom_range(3, 60));
            pix_q.delete();
        end

        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));

        if (AUTO) $display("[TB] mean_done pulses seen: %0d", n_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_mean_binarize.md
# gray_mean_binarize

Adaptive binarization stage directly downstream of the 3×3 gray median filter. It consumes the filtered gray stream and measures the mean gray level of each complete frame. It then binarizes the next frame against that mean: a pixel becomes 8'hFF if above the threshold, 8'h00 otherwise. The output stream keeps the vsync/href framing and feeds edge detection and the display path.

## Interface
Parameters:
- IMG_HDISP, 11'd640, active pixels per line
- IMG_VDISP, 11'd480, active lines per frame
- THRESH_INIT, 8'd128, threshold used until the first frame mean is available

Ports:
- clk  input  1  pixel clock. One clock domain; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset
- per_frame_vsync  input  1  high for the whole frame, low in vertical blanking
- per_frame_href  input  1  high for each valid gray pixel
- per_img_Gray  input  8  filtered gray pixel
- post_frame_vsync  output  1  per_frame_vsync delayed 1 cycle
- post_frame_href  output  1  per_frame_href delayed 1 cycle
- post_img_Bit  output  8  8'hFF or 8'h00; forced to 0 when post_frame_href is low
- cur_thresh  output  8  threshold applied to the current frame
- mean_done  output  1  one-cycle pulse when a new mean has been computed

## Operation
- The input accumulator is cleared on the rising edge of vsync. While vsync=1 and href=1, each cycle adds the pixel to sum (SUM_W=30) and increments cnt (CNT_W=22).
- Falling edge of vsync (end of frame) behaves as follows:
  - cnt≠0: sum and cnt are latched into gray_mean_divider and the divider starts.
  - cnt=0: no division; mean_done is not pulsed; the pending threshold is unchanged.
- gray_mean_divider is a restoring divider producing one quotient bit per cycle over 30 cycles: IDLE → BUSY → DONE → IDLE.
  - In DONE, the quotient is saturated to 8'hFF if above 255 (it cannot exceed 255 with valid input; the clamp is defensive).
  - The result is written to pend_thresh, and mean_done pulses for one cycle.
- On the rising edge of vsync, pend_thresh is copied to cur_thresh. The threshold therefore never changes in the middle of a frame.
- If a vsync rising edge occurs while the divider is BUSY, cur_thresh keeps the old pend_thresh. The divider finishes its work and its result applies from the following frame. A new end of frame while BUSY is ignored; the running division is not restarted.
- Binarization is registered: post_img_Bit = (href && gray > cur_thresh) ? 8'hFF : 8'h00. A pixel equal to the threshold gives 8'h00.
- Reset values:
  - post_frame_vsync, post_frame_href, post_img_Bit, mean_done = 0
  - cur_thresh = pend_thresh = THRESH_INIT
  - sum, cnt = 0; divider in IDLE
- Reset asserted in the middle of a frame or division aborts everything and restores the reset values. The first frame after reset is accumulated normally, even if vsync is already high when reset is released.

## Timing
- Pixel path latency is exactly 1 cycle. The vsync/href/Bit alignment is preserved.
- Divider timing: the end-of-frame edge is detected in cycle N. The divider starts in cycle N+1. mean_done and pend_thresh update in cycle N+32.
- cur_thresh updates 1 cycle after the vsync rising edge is sampled. It is valid before the first href of the frame, which requires ≥2 cycles between vsync rising and the first href.
- Vertical blanking must be ≥33 cycles for the new mean to apply to the very next frame; otherwise it applies one frame later.

## Configuration
- AUTO_THRESH_EN defined: the full adaptive behaviour described above.
- AUTO_THRESH_EN undefined:
  - accumulator and divider are not built
  - cur_thresh is constant THRESH_INIT
  - mean_done is tied to 0
  - the pixel path and its latency are unchanged

## Structure
- Package gray_bin_pkg holds:
  - SUM_W=30, CNT_W=22
  - the divider state enum (IDLE, BUSY, DONE)
  - the constants BIN_HI=8'hFF and BIN_LO=8'h00
- One sub-module, gray_mean_divider: a 30-bit by 22-bit sequential restoring divider with start/done handshake and an 8-bit saturated quotient.
- The top level holds the edge detectors, accumulator, threshold registers and pixel pipeline.

## Test plan
- Reset check: hold rst_n=0 with random inputs → all outputs 0 except cur_thresh=128; after release, a pixel of 129 → 8'hFF and a pixel of 128 → 8'h00.
- Mean update: IMG_HDISP=4, IMG_VDISP=2, frame 1 all pixels 40 with 50 cycles of blanking → mean_done pulses 32 cycles after vsync falls; in frame 2, cur_thresh=40, gray 41 → 8'hFF, gray 40 → 8'h00.
- Truncating mean: 8 pixels {0,0,0,0,255,255,255,254} → sum=1019, mean=127 (truncated); cur_thresh becomes 127 at the next vsync rising edge.
- Short blanking: 10-cycle blanking after a frame with mean 200 → the next frame still uses the old threshold; the frame after uses 200.
- Empty frame: a vsync pulse with no href → no mean_done; cur_thresh unchanged.
- Mid-operation reset: assert rst_n=0 16 cycles into a division → mean_done never pulses; cur_thresh=128 after release.
- Compile-out build: AUTO_THRESH_EN undefined with a frame of all pixels 40 → cur_thresh stays 128 and every output pixel is 8'h00.
